video_bringup_seq: RTL and testbench

VIDEO_BRINGUP_SEQ -- requirements
Module: video_bringup_seq

---
 rtl/video_bringup_seq.sv | 151 +++++++++++++++
 tb/tb_video_bringup_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/video_bringup_seq.sv
// Video bring-up sequencer: POR -> PLL lock -> generator reset -> HDMI I2C config -> RUN, with retries and fault.
// All outputs registered (one cycle after the state decision); async inputs seen through 2-FF synchronizers.
module video_bringup_seq #(
    parameter int POR_CYCLES     = 24000,
    parameter int LOCK_STABLE    = 2400,
    parameter int LOCK_TIMEOUT   = 240000,
    parameter int GEN_RST_CYCLES = 16,
    parameter int I2C_TIMEOUT    = 2400000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       clk24M,
    input  logic       reset_n,
    input  logic       pll_lock,
    input  logic       i2c_done,
    input  logic       restart,
    output logic       pll_rst,
    output logic       gen_rstn,
    output logic       i2c_rstn,
    output logic       i2c_start,
    output logic       video_en,
    output logic       fault,
    output logic [2:0] state,
    output logic [1:0] retry_cnt
);

    typedef enum logic [2:0] {
        S_POR      = 3'd0,
        S_PLL_WAIT = 3'd1,
        S_GEN_RST  = 3'd2,
        S_I2C_CFG  = 3'd3,
        S_RUN      = 3'd4,
        S_FAULT    = 3'd5
    } state_t;

    localparam logic [23:0] POR_LAST  = 24'(POR_CYCLES - 1);
    localparam logic [23:0] STAB_LAST = 24'(LOCK_STABLE - 1);
    localparam logic [23:0] LOCK_LAST = 24'(LOCK_TIMEOUT - 1);
    localparam logic [23:0] GEN_LAST  = 24'(GEN_RST_CYCLES - 1);
    localparam logic [23:0] CFG_LAST  = 24'(I2C_TIMEOUT - 1);
    localparam logic [1:0]  MAX_R     = 2'(MAX_RETRIES);

    state_t      cur_state, nxt_state;
    logic        lock_s1, lock_s, done_s1, done_s;
    logic [23:0] cnt, cnt_nxt;
    logic [23:0] stab, stab_nxt;
    logic [1:0]  retry_nxt;
    logic        entry;
    logic        pll_rst_d, gen_rstn_d, i2c_rstn_d, i2c_start_d, video_en_d, fault_d;

    assign state = cur_state;

    always_comb begin
        nxt_state = cur_state;
        retry_nxt = retry_cnt;
        case (cur_state)
            S_POR: begin
                if (cnt == POR_LAST)
                    nxt_state = S_PLL_WAIT;
            end
            S_PLL_WAIT: begin
                if (lock_s && stab == STAB_LAST) begin
                    nxt_state = S_GEN_RST;
                end else if (cnt == LOCK_LAST) begin
                    if (retry_cnt < MAX_R) begin
                        retry_nxt = retry_cnt + 2'd1;
                        nxt_state = S_POR;
                    end else begin
                        nxt_state = S_FAULT;
                    end
                end
            end
            S_GEN_RST: begin
                if (cnt == GEN_LAST)
                    nxt_state = S_I2C_CFG;
            end
            S_I2C_CFG: begin
                if (done_s) begin
                    nxt_state = S_RUN;
                    retry_nxt = 2'd0;
                end else if (cnt == CFG_LAST) begin
                    // A config timeout only re-runs the generator/I2C reset; the PLL is left alone.
                    if (retry_cnt < MAX_R) begin
                        retry_nxt = retry_cnt + 2'd1;
                        nxt_state = S_GEN_RST;
                    end else begin
                        nxt_state = S_FAULT;
                    end
                end
            end
            S_RUN: begin
                if (!lock_s)
                    nxt_state = S_POR;
            end
            S_FAULT: nxt_state = S_FAULT;
            default: nxt_state = S_POR;
        endcase
        if (restart) begin
            nxt_state = S_POR;
            retry_nxt = 2'd0;
        end

        entry    = restart || (nxt_state != cur_state);
        cnt_nxt  = entry ? 24'd0 : cnt + 24'd1;
        stab_nxt = (!entry && cur_state == S_PLL_WAIT && lock_s) ? stab + 24'd1 : 24'd0;
    end

    // Outputs are decoded from the next state so the registered copies line up with `state`.
    always_comb begin
        pll_rst_d   = (nxt_state == S_POR) || (nxt_state == S_FAULT);
        gen_rstn_d  = (nxt_state == S_I2C_CFG) || (nxt_state == S_RUN);
        i2c_rstn_d  = gen_rstn_d;
        i2c_start_d = (nxt_state == S_I2C_CFG) && (cur_state != S_I2C_CFG);
        video_en_d  = (nxt_state == S_RUN);
        fault_d     = (nxt_state == S_FAULT);
    end

    always_ff @(posedge clk24M or negedge reset_n) begin
        if (!reset_n) begin
            lock_s1   <= 1'b0;
            lock_s    <= 1'b0;
            done_s1   <= 1'b0;
            done_s    <= 1'b0;
            cur_state <= S_POR;
            cnt       <= 24'd0;
            stab      <= 24'd0;
            retry_cnt <= 2'd0;
            pll_rst   <= 1'b1;
            gen_rstn  <= 1'b0;
            i2c_rstn  <= 1'b0;
            i2c_start <= 1'b0;
            video_en  <= 1'b0;
            fault     <= 1'b0;
        end else begin
            lock_s1   <= pll_lock;
            lock_s    <= lock_s1;
            done_s1   <= i2c_done;
            done_s    <= done_s1;
            cur_state <= nxt_state;
            cnt       <= cnt_nxt;
            stab      <= stab_nxt;
            retry_cnt <= retry_nxt;
            pll_rst   <= pll_rst_d;
            gen_rstn  <= gen_rstn_d;
            i2c_rstn  <= i2c_rstn_d;
            i2c_start <= i2c_start_d;
            video_en  <= video_en_d;
            fault     <= fault_d;
        end
    end

endmodule

// File: tb/tb_video_bringup_seq.sv
// Directed bench for video_bringup_seq: vector table of {inputs, hold cycles, expected outputs} plus async-reset sequence.
module tb_video_bringup_seq;

    localparam logic [2:0] S_POR  = 3'd0;
    localparam logic [2:0] S_PLLW = 3'd1;
    localparam logic [2:0] S_GEN  = 3'd2;
    localparam logic [2:0] S_CFG  = 3'd3;
    localparam logic [2:0] S_RUN  = 3'd4;
    localparam logic [2:0] S_FLT  = 3'd5;

    typedef struct packed {
        logic [2:0] st;
        logic       pll_rst;
        logic       gen_rstn;
        logic       i2c_rstn;
        logic       i2c_start;
        logic       video_en;
        logic       fault;
        logic [1:0] retry;
    } exp_t;

    typedef struct {
        logic rst;
        logic lock;
        logic done;
        logic rs;
        int   hold;
        exp_t exp;
    } vec_t;

    logic       clk24M = 1'b0;
    logic       reset_n;
    logic       pll_lock, i2c_done, restart;
    logic       pll_rst, gen_rstn, i2c_rstn, i2c_start, video_en, fault;
    logic [2:0] state;
    logic [1:0] retry_cnt;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    video_bringup_seq #(
        .POR_CYCLES(8), .LOCK_STABLE(4), .LOCK_TIMEOUT(32),
        .GEN_RST_CYCLES(4), .I2C_TIMEOUT(64), .MAX_RETRIES(2)
    ) dut (
        .clk24M(clk24M), .reset_n(reset_n), .pll_lock(pll_lock), .i2c_done(i2c_done),
        .restart(restart), .pll_rst(pll_rst), .gen_rstn(gen_rstn), .i2c_rstn(i2c_rstn),
        .i2c_start(i2c_start), .video_en(video_en), .fault(fault), .state(state),
        .retry_cnt(retry_cnt)
    );

    always #5 clk24M = ~clk24M;

    // Output levels required in each state.
    function automatic exp_t ex(input logic [2:0] st, input logic start, input logic [1:0] rc);
        exp_t e;
        e = '0;
        e.st = st;
        e.i2c_start = start;
        e.retry = rc;
        case (st)
            S_POR:  begin e.pll_rst = 1'b1; end
            S_CFG:  begin e.gen_rstn = 1'b1; e.i2c_rstn = 1'b1; end
            S_RUN:  begin e.gen_rstn = 1'b1; e.i2c_rstn = 1'b1; e.video_en = 1'b1; end
            S_FLT:  begin e.pll_rst = 1'b1; e.fault = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic add(input logic rst, input logic lock, input logic done, input logic rs,
                       input int hold, input logic [2:0] st, input logic start, input logic [1:0] rc);
        vec_t v;
        v.rst = rst; v.lock = lock; v.done = done; v.rs = rs; v.hold = hold;
        v.exp = ex(st, start, rc);
        vecs.push_back(v);
    endtask

    task automatic check(input exp_t e, input string nm, input int id);
        exp_t a;
        a = {state, pll_rst, gen_rstn, i2c_rstn, i2c_start, video_en, fault, retry_cnt};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s%0d: got st=%0d pll_rst=%b gen_rstn=%b i2c_rstn=%b start=%b ven=%b fault=%b retry=%0d want st=%0d pll_rst=%b gen_rstn=%b i2c_rstn=%b start=%b ven=%b fault=%b retry=%0d",
                     nm, id, a.st, a.pll_rst, a.gen_rstn, a.i2c_rstn, a.i2c_start, a.video_en, a.fault, a.retry,
                     e.st, e.pll_rst, e.gen_rstn, e.i2c_rstn, e.i2c_start, e.video_en, e.fault, e.retry);
        end
    endtask

    initial begin
        // Nominal: lock tied high, i2c_done 10 cycles after i2c_start
        add(1, 1, 0, 0,  7, S_POR,  0, 0);
        add(0, 1, 0, 0,  1, S_PLLW, 0, 0);
        add(0, 1, 0, 0,  3, S_PLLW, 0, 0);
        add(0, 1, 0, 0,  1, S_GEN,  0, 0);
        add(0, 1, 0, 0,  3, S_GEN,  0, 0);
        add(0, 1, 0, 0,  1, S_CFG,  1, 0);
        add(0, 1, 0, 0,  1, S_CFG,  0, 0);
        add(0, 1, 0, 0,  9, S_CFG,  0, 0);
        add(0, 1, 1, 0,  2, S_CFG,  0, 0);
        add(0, 1, 1, 0,  1, S_RUN,  0, 0);
        add(0, 1, 1, 0,  5, S_RUN,  0, 0);
        // Lock never asserts: three timeouts, FAULT, then restart out of FAULT
        add(1, 0, 0, 0,  8, S_PLLW, 0, 0);
        add(0, 0, 0, 0, 31, S_PLLW, 0, 0);
        add(0, 0, 0, 0,  1, S_POR,  0, 1);
        add(0, 0, 0, 0,  8, S_PLLW, 0, 1);
        add(0, 0, 0, 0, 31, S_PLLW, 0, 1);
        add(0, 0, 0, 0,  1, S_POR,  0, 2);
        add(0, 0, 0, 0,  8, S_PLLW, 0, 2);
        add(0, 0, 0, 0, 31, S_PLLW, 0, 2);
        add(0, 0, 0, 0,  1, S_FLT,  0, 2);
        add(0, 0, 0, 0, 10, S_FLT,  0, 2);
        add(0, 0, 0, 1,  1, S_POR,  0, 0);
        add(0, 0, 0, 0,  7, S_POR,  0, 0);
        add(0, 0, 0, 0,  1, S_PLLW, 0, 0);
        // Lock glitch: 3 high, 1 low, then high; stability restarts
        add(1, 0, 0, 0,  8, S_PLLW, 0, 0);
        add(0, 1, 0, 0,  3, S_PLLW, 0, 0);
        add(0, 0, 0, 0,  1, S_PLLW, 0, 0);
        add(0, 1, 0, 0,  5, S_PLLW, 0, 0);
        add(0, 1, 0, 0,  1, S_GEN,  0, 0);
        // Config timeout, second attempt succeeds, then lock loss in RUN
        add(1, 1, 0, 0, 16, S_CFG,  1, 0);
        add(0, 1, 0, 0, 63, S_CFG,  0, 0);
        add(0, 1, 0, 0,  1, S_GEN,  0, 1);
        add(0, 1, 0, 0,  3, S_GEN,  0, 1);
        add(0, 1, 0, 0,  1, S_CFG,  1, 1);
        add(0, 1, 1, 0,  2, S_CFG,  0, 1);
        add(0, 1, 1, 0,  1, S_RUN,  0, 0);
        add(0, 0, 1, 0,  2, S_RUN,  0, 0);
        add(0, 0, 1, 0,  1, S_POR,  0, 0);
        // Restart in the same cycle done_s rises
        add(1, 1, 0, 0, 16, S_CFG,  1, 0);
        add(0, 1, 1, 0,  2, S_CFG,  0, 0);
        add(0, 1, 1, 1,  1, S_POR,  0, 0);
        add(0, 1, 1, 0,  1, S_POR,  0, 0);

        reset_n  = 1'b0;
        pll_lock = 1'b0;
        i2c_done = 1'b0;
        restart  = 1'b0;
        repeat (2) @(posedge clk24M);
        #1;

        foreach (vecs[i]) begin
            pll_lock = vecs[i].lock;
            i2c_done = vecs[i].done;
            restart  = vecs[i].rs;
            if (vecs[i].rst) begin
                reset_n = 1'b0;
                #2;
                check(ex(S_POR, 0, 0), "rst", i);
                @(posedge clk24M);
                @(posedge clk24M);
                #1 reset_n = 1'b1;
            end
            repeat (vecs[i].hold) @(posedge clk24M);
            #1;
            check(vecs[i].exp, "vec", i);
        end

        // Async reset asserted during the i2c_start cycle of I2C_CFG
        pll_lock = 1'b1;
        i2c_done = 1'b0;
        restart  = 1'b0;
        reset_n  = 1'b0;
        @(posedge clk24M);
        #1 reset_n = 1'b1;
        repeat (16) @(posedge clk24M);
        #1;
        check(ex(S_CFG, 1, 0), "cfg_pre_rst", 0);
        #2 reset_n = 1'b0;
        #1;
        check(ex(S_POR, 0, 0), "async_rst", 0);
        @(posedge clk24M);
        #1;
        check(ex(S_POR, 0, 0), "rst_hold", 0);
        reset_n = 1'b1;
        repeat (7) @(posedge clk24M);
        #1;
        check(ex(S_POR, 0, 0), "post_rst_por", 0);
        @(posedge clk24M);
        #1;
        check(ex(S_PLLW, 0, 0), "post_rst_pllw", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
